// File: rtl/max1000_led_exerciser.sv
// MAX1000 LED exerciser: walks/counts/bounces/blinks N_LEDS from a
// step prescaler, a debounced USER_BTN advances the mode, HEARTBEAT
// toggles every 4th step. Optional UART mode report when
// MAX1000_LED_UART_STATUS_EN is defined (BDBUS1 is idle-high otherwise).
// Ports: CLK12M clock, RESET async active-low, USER_BTN active-low,
// LED[N_LEDS-1:0], MODE[1:0], HEARTBEAT, BDBUS1 (UART TX).
module max1000_led_exerciser #(
  parameter int N_LEDS      = 8,
  parameter int CLK_HZ      = 12000000,
  parameter int STEP_HZ     = 8,
  parameter int DEBOUNCE_MS = 20,
  parameter int BAUD        = 115200
) (
  input  logic              CLK12M,
  input  logic              RESET,
  input  logic              USER_BTN,
  output logic [N_LEDS-1:0] LED,
  output logic [1:0]        MODE,
  output logic              HEARTBEAT,
  output logic              BDBUS1
);

  typedef enum logic [1:0] {
    WALK   = 2'd0,
    COUNT  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  localparam int CYC_STEP = CLK_HZ / STEP_HZ;
  localparam int DB_CYC =
    int'(longint'(DEBOUNCE_MS) * CLK_HZ / 1000);
  localparam int PW = $clog2(CYC_STEP);
  localparam int DW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CYC_STEP - 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DB_CYC - 1);
  localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);

  if (N_LEDS < 1 || N_LEDS > 32) begin : g_bad_n
    $error("N_LEDS out of range 1..32");
  end
  if (CYC_STEP < 2) begin : g_bad_step
    $error("CLK_HZ/STEP_HZ must be >= 2");
  end
  if (DB_CYC < 1) begin : g_bad_db
    $error("DEBOUNCE_MS*CLK_HZ/1000 must be >= 1");
  end
  if (BAUD < 1) begin : g_bad_baud
    $error("BAUD must be positive");
  end

  logic [PW-1:0]     pre;
  logic              tick;
  logic              s1, s2, stable;
  logic [DW-1:0]     db_cnt;
  logic              press;
  mode_t             mode, mode_nxt;
  logic [N_LEDS-1:0] led, led_nxt;
  logic              up, up_nxt;
  logic [1:0]        hb_cnt;
  logic              hb;

  assign tick  = (pre == PRE_MAX);
  assign press = (s2 != stable) && (db_cnt == DB_MAX) && !s2;

  always_ff @(posedge CLK12M or negedge RESET) begin
    if (!RESET) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      db_cnt <= '0;
    end else begin
      s1 <= USER_BTN;
      s2 <= s1;
      if (s2 != stable) begin
        if (db_cnt == DB_MAX) begin
          stable <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge CLK12M or negedge RESET) begin
    if (!RESET) begin
      pre    <= '0;
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else begin
      if (press || tick) pre <= '0;
      else               pre <= pre + PW'(1);
      // Heartbeat sees every tick, even one a press discards.
      if (tick) begin
        hb_cnt <= hb_cnt + 2'd1;
        if (hb_cnt == 2'd3) hb <= ~hb;
      end
    end
  end

  always_ff @(posedge CLK12M or negedge RESET) begin
    if (!RESET) begin
      mode <= WALK;
      led  <= ONE;
      up   <= 1'b1;
    end else begin
      mode <= mode_nxt;
      led  <= led_nxt;
      up   <= up_nxt;
    end
  end

  always_comb begin
    mode_nxt = mode;
    led_nxt  = led;
    up_nxt   = up;
    if (press) begin
      mode_nxt = mode_t'(mode + 2'd1);
      up_nxt   = 1'b1;
      unique case (mode_nxt)
        WALK:    led_nxt = ONE;
        COUNT:   led_nxt = '0;
        BOUNCE:  led_nxt = ONE;
        default: led_nxt = '1;
      endcase
    end else if (tick) begin
      unique case (mode)
        WALK:
          led_nxt = (led << 1) | (led >> (N_LEDS - 1));
        COUNT:
          led_nxt = led + ONE;
        BOUNCE: begin
          if (N_LEDS == 1) begin
            led_nxt = led;
          end else if (up) begin
            if (led[N_LEDS-1]) begin
              up_nxt  = 1'b0;
              led_nxt = led >> 1;
            end else begin
              led_nxt = led << 1;
            end
          end else begin
            if (led[0]) begin
              up_nxt  = 1'b1;
              led_nxt = led << 1;
            end else begin
              led_nxt = led >> 1;
            end
          end
        end
        default:
          led_nxt = ~led;
      endcase
    end
  end

  assign LED       = led;
  assign MODE      = mode;
  assign HEARTBEAT = hb;

`ifdef MAX1000_LED_UART_STATUS_EN
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] BIT_MAX = CW'(BIT_CYC - 1);

  if (BIT_CYC < 1) begin : g_bad_bit
    $error("CLK_HZ/BAUD must be >= 1");
  end

  logic [9:0]    sh;
  logic [3:0]    bit_idx;
  logic [CW-1:0] bcyc;
  logic          busy, pend, done, ld;
  logic [7:0]    pend_d, digit, ld_d;

  assign digit = 8'h30 + {6'd0, mode_nxt};
  assign done  = busy && (bcyc == BIT_MAX) && (bit_idx == 4'd9);
  // A press landing on the last stop-bit cycle sends the newest digit.
  assign ld    = (press && (!busy || done)) || (done && pend);
  assign ld_d  = press ? digit : pend_d;

  always_ff @(posedge CLK12M or negedge RESET) begin
    if (!RESET) begin
      sh      <= '1;
      bit_idx <= '0;
      bcyc    <= '0;
      busy    <= 1'b0;
      pend    <= 1'b0;
      pend_d  <= '0;
    end else begin
      if (press && busy && !done) begin
        pend   <= 1'b1;
        pend_d <= digit;
      end else if (ld) begin
        pend <= 1'b0;
      end
      if (ld) begin
        sh      <= {1'b1, ld_d, 1'b0};
        bit_idx <= '0;
        bcyc    <= '0;
        busy    <= 1'b1;
      end else if (done) begin
        sh   <= '1;
        busy <= 1'b0;
      end else if (busy) begin
        if (bcyc == BIT_MAX) begin
          bcyc    <= '0;
          bit_idx <= bit_idx + 4'd1;
          sh      <= {1'b1, sh[9:1]};
        end else begin
          bcyc <= bcyc + CW'(1);
        end
      end
    end
  end

  assign BDBUS1 = sh[0];
`else
  assign BDBUS1 = 1'b1;
`endif

endmodule

// File: tb/tb_max1000_led_exerciser.sv
// Bench for max1000_led_exerciser: directed plus random button
// activity compared every cycle against a tick/step-count model.
module tb_max1000_led_exerciser;

  localparam int NL   = 8;
  localparam int CHZ  = 1000;
  localparam int SHZ  = 100;
  localparam int DMS  = 2;
  localparam int STEP = CHZ / SHZ;
  localparam int DB   = DMS * CHZ / 1000;
`ifdef MAX1000_LED_UART_STATUS_EN
  localparam int BD   = 100;
  localparam int BITC = CHZ / BD;
`else
  localparam int BD   = 115200;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn;
  logic [NL-1:0] led;
  logic [1:0]    mode;
  logic          hb;
  logic          tx;

  int n_chk = 0;
  int n_err = 0;

  max1000_led_exerciser #(
    .N_LEDS(NL), .CLK_HZ(CHZ), .STEP_HZ(SHZ),
    .DEBOUNCE_MS(DMS), .BAUD(BD)
  ) dut (
    .CLK12M(clk), .RESET(rst_n), .USER_BTN(btn),
    .LED(led), .MODE(mode), .HEARTBEAT(hb), .BDBUS1(tx)
  );

  always #5 clk = ~clk;

  // model state
  int  m_mode, m_steps, m_since, m_ticks, m_run;
  bit  m_stable;
  bit  hq[$];
  bit  u_act, u_pend;
  int  u_t;
  logic [7:0] u_cur, u_pd;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_steps = 0; m_since = 0;
    m_ticks = 0; m_run = 0; m_stable = 1;
    hq = {1'b1, 1'b1};
    u_act = 0; u_pend = 0; u_t = 0;
    u_cur = 0; u_pd = 0;
  endtask

  function automatic logic [NL-1:0] exp_led();
    int p;
    case (m_mode)
      0: return NL'(1) << (m_steps % NL);
      1: return NL'(m_steps % (1 << NL));
      2: begin
        p = m_steps % (2 * NL - 2);
        return NL'(1) << ((p < NL) ? p : 2 * NL - 2 - p);
      end
      default: return (m_steps % 2) ? '0 : '1;
    endcase
  endfunction

  function automatic logic exp_tx();
`ifdef MAX1000_LED_UART_STATUS_EN
    int b;
    if (!u_act) return 1'b1;
    b = u_t / BITC;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return u_cur[b-1];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step(input bit b);
    bit syn, press, tick;
    hq.push_back(b);
    syn = hq.pop_front();
    press = 0;
    if (syn != m_stable) begin
      m_run++;
      if (m_run == DB) begin
        m_stable = syn;
        m_run = 0;
        press = !syn;
      end
    end else begin
      m_run = 0;
    end
    tick = (m_since + 1 == STEP);
    if (tick) m_ticks++;
    if (press) begin
      m_mode = (m_mode + 1) % 4;
      m_steps = 0;
      m_since = 0;
    end else begin
      m_since = tick ? 0 : m_since + 1;
      if (tick) m_steps++;
    end
`ifdef MAX1000_LED_UART_STATUS_EN
    if (u_act) begin
      u_t++;
      if (u_t == 10 * BITC) u_act = 0;
    end
    if (press) begin
      if (!u_act) begin
        u_act = 1; u_t = 0;
        u_cur = 8'h30 + 8'(m_mode);
        u_pend = 0;
      end else begin
        u_pend = 1;
        u_pd = 8'h30 + 8'(m_mode);
      end
    end
    if (!u_act && u_pend) begin
      u_act = 1; u_t = 0;
      u_cur = u_pd; u_pend = 0;
    end
`endif
  endtask

  task automatic check_all();
    chk("led", 32'(led), 32'(exp_led()));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("hb", 32'(hb), 32'((m_ticks / 4) % 2));
    chk("tx", 32'(tx), 32'(exp_tx()));
  endtask

  task automatic cyc(input bit b);
    btn = b;
    @(posedge clk);
    if (rst_n) model_step(b);
    else model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n, input bit b);
    for (int i = 0; i < n; i++) cyc(b);
  endtask

  task automatic push(input int hold);
    run(hold, 1'b0);
    run(6, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    btn = 1'b1;
    model_reset();
    @(negedge clk);
    run(3, 1'b1);
    rst_n = 1'b1;
    // walk, wrap and heartbeat
    run(95, 1'b1);
    // glitch, then real press, then release
    run(1, 1'b0);
    run(6, 1'b1);
    run(10, 1'b0);
    run(30, 1'b1);
    // bounce, blink, walk
    push(4);
    run(160, 1'b1);
    push(4);
    run(40, 1'b1);
    push(4);
    run(20, 1'b1);
    // count wraps 0xFF -> 0x00
    push(4);
    run(2600, 1'b1);
    // press lands on a tick edge
    for (int i = 0; i < 2 * STEP; i++) begin
      if (m_since == STEP - 4) break;
      cyc(1'b1);
    end
    chk("align", 32'(m_since), 32'(STEP - 4));
    run(6, 1'b0);
    run(30, 1'b1);
    // UART frame, then two presses mid-frame
    push(4);
    run(110, 1'b1);
    push(4);
    run(10, 1'b1);
    push(4);
    run(10, 1'b1);
    push(4);
    run(250, 1'b1);
    // reset mid-frame
    push(4);
    run(25, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_led", 32'(led), 32'd1);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_hb", 32'(hb), 32'd0);
    model_reset();
    @(negedge clk);
    run(3, 1'b1);
    rst_n = 1'b1;
    run(20, 1'b1);
    // random button activity
    for (int k = 0; k < 120; k++) begin
      run($urandom_range(1, 12), 1'($urandom_range(0, 1)));
    end
    run(40, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
